// File: rtl/rho_cim_pkg.sv
// Shared types and helpers for the rho CiM datapath.
// Func-unit and input-buffer state machines live side by side here.
package rho_cim_pkg;

  typedef enum logic [1:0] {
    s_func_idle,
    s_func_acc,
    s_func_act,
    s_func_out
  } t_func_state;

  typedef enum logic [2:0] {
    s_ibuf_fill,
    s_ibuf_arm,
    s_ibuf_start,
    s_ibuf_wait,
    s_ibuf_done
  } t_ibuf_state;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int clog2_min1(input int val);
    return (val > 1) ? $clog2(val) : 1;
  endfunction

endpackage

// File: rtl/fc_inbuf_plane_mux.sv
// Buffer to crossbar bit-plane select.
// Rows past the end of the frame are tied low as padding.
module fc_inbuf_plane_mux
  import rho_cim_pkg::*;
#(
  parameter int input_size    = 512,
  parameter int xbar_size     = 256,
  parameter int v_cim_tiles   = ceil_div(input_size, xbar_size),
  parameter int datatype_size = 8
) (
  input  logic [input_size-1:0][datatype_size-1:0] data,
  input  logic [$clog2(datatype_size)-1:0]         bit_idx,
  output logic [v_cim_tiles-1:0][xbar_size-1:0]    plane
);

  for (genvar t = 0; t < v_cim_tiles; t++) begin : g_tile
    for (genvar r = 0; r < xbar_size; r++) begin : g_row
      if (t * xbar_size + r < input_size) begin : g_live
        assign plane[t][r] = data[t*xbar_size+r][bit_idx];
      end else begin : g_pad
        assign plane[t][r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fc_inbuf.sv
// FC-layer input buffer: collects a frame of activations,
// then feeds it to the CiM tiles one bit-plane at a time, LSB first.
module fc_inbuf
  import rho_cim_pkg::*;
#(
  parameter int input_size    = 512,
  parameter int xbar_size     = 256,
  parameter int v_cim_tiles   = ceil_div(input_size, xbar_size),
  parameter int datatype_size = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  logic [datatype_size-1:0]              i_data,
  output logic                                  o_busy,
  input  logic                                  i_cim_busy,
  output logic                                  o_cim_start,
  output logic [v_cim_tiles-1:0][xbar_size-1:0] o_cim_data,
  output logic [$clog2(datatype_size)-1:0]      o_bit_idx,
  output logic                                  o_done
);

  localparam int aw = clog2_min1(input_size);
  localparam int bw = $clog2(datatype_size);
  localparam logic [aw-1:0] last_addr = aw'(input_size - 1);
  localparam logic [bw-1:0] last_bit  = bw'(datatype_size - 1);

  t_ibuf_state state;
  logic [aw-1:0] wr_addr;
  logic          first_wait;

  logic [input_size-1:0][datatype_size-1:0] mem;

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == s_ibuf_fill && i_valid)
      mem[wr_addr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= s_ibuf_fill;
      wr_addr     <= '0;
      first_wait  <= 1'b0;
      o_bit_idx   <= '0;
      o_busy      <= 1'b0;
      o_cim_start <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_cim_start <= 1'b0;
      o_done      <= 1'b0;
      unique case (1'b1)
        (state == s_ibuf_fill): begin
          if (i_valid) begin
            if (wr_addr == last_addr) begin
              wr_addr <= '0;
              state   <= s_ibuf_arm;
              o_busy  <= 1'b1;
            end else begin
              wr_addr <= wr_addr + aw'(1);
            end
          end
        end
        (state == s_ibuf_arm): begin
          if (!i_cim_busy) begin
            state       <= s_ibuf_start;
            o_cim_start <= 1'b1;
          end
        end
        (state == s_ibuf_start): begin
          state      <= s_ibuf_wait;
          first_wait <= 1'b1;
        end
        // CiM raises busy one cycle late, so the first
        // wait cycle can never end the plane.
        (state == s_ibuf_wait): begin
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (!i_cim_busy) begin
            if (o_bit_idx != last_bit) begin
              o_bit_idx <= o_bit_idx + bw'(1);
              state     <= s_ibuf_arm;
            end else begin
              state  <= s_ibuf_done;
              o_done <= 1'b1;
            end
          end
        end
        (state == s_ibuf_done): begin
          o_bit_idx <= '0;
          state     <= s_ibuf_fill;
          o_busy    <= 1'b0;
        end
        default: begin
          state  <= s_ibuf_fill;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  fc_inbuf_plane_mux #(
    .input_size    (input_size),
    .xbar_size     (xbar_size),
    .v_cim_tiles   (v_cim_tiles),
    .datatype_size (datatype_size)
  ) u_plane_mux (
    .data    (mem),
    .bit_idx (o_bit_idx),
    .plane   (o_cim_data)
  );

endmodule

// File: tb/tb_fc_inbuf.sv
// Directed bench for fc_inbuf with a 3-row, 2-tile, 4-bit config.
// Plane values are packed {tile1, tile0}, row 0 in the LSB of each tile.
module tb_fc_inbuf;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic [3:0]      i_data;
  logic            o_busy;
  logic            i_cim_busy;
  logic            o_cim_start;
  logic [1:0][1:0] o_cim_data;
  logic [1:0]      o_bit_idx;
  logic            o_done;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  logic [3:0] exp_pl [4];

  fc_inbuf #(
    .input_size    (3),
    .xbar_size     (2),
    .datatype_size (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_busy      (o_busy),
    .i_cim_busy  (i_cim_busy),
    .o_cim_start (o_cim_start),
    .o_cim_data  (o_cim_data),
    .o_bit_idx   (o_bit_idx),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_cim_start) n_start++;
    if (o_done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!o_cim_start && k < 30) begin
      tick();
      k++;
    end
    check("start_seen", o_cim_start, 1);
  endtask

  // Runs planes 0..n-1 with CiM busy for 5 cycles each.
  task automatic run_planes(input int n);
    for (int b = 0; b < n; b++) begin
      wait_start();
      check("bit_idx", o_bit_idx, b);
      check("plane", o_cim_data, exp_pl[b]);
      i_cim_busy = 1'b1;
      tick();
      check("start_one_cycle", o_cim_start, 0);
      repeat (5) tick();
      check("plane_stable", o_cim_data, exp_pl[b]);
      i_cim_busy = 1'b0;
      tick();
      if (b < 3) begin
        check("arm_no_start", o_cim_start, 0);
      end else begin
        check("done_pulse", o_done, 1);
        check("busy_in_done", o_busy, 1);
        i_valid = 1'b0;
        tick();
        check("done_cleared", o_done, 0);
        check("busy_after_done", o_busy, 0);
        check("bit_idx_cleared", o_bit_idx, 0);
      end
    end
  endtask

  task automatic write_word(input logic [3:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    int s0;
    int d0;
    rst = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    i_cim_busy = 1'b0;
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_start", o_cim_start, 0);
    check("rst_done", o_done, 0);
    check("rst_bit_idx", o_bit_idx, 0);
    tick();
    rst = 1'b0;
    tick();

    // Frame A: 3, 5, 10 back to back; 15 held on the bus while busy.
    exp_pl = '{4'b0011, 4'b0101, 4'b0010, 4'b0100};
    s0 = n_start;
    d0 = n_done;
    i_valid = 1'b1;
    i_data = 4'd3;
    tick();
    check("a_busy_w1", o_busy, 0);
    i_data = 4'd5;
    tick();
    check("a_busy_w2", o_busy, 0);
    i_data = 4'd10;
    tick();
    check("a_busy_w3", o_busy, 1);
    i_data = 4'd15;
    check("a_arm_no_start", o_cim_start, 0);
    check("a_plane0_arm", o_cim_data, 4'b0011);
    tick();
    check("a_first_start", o_cim_start, 1);
    run_planes(4);
    check("a_start_count", n_start - s0, 4);
    check("a_done_count", n_done - d0, 1);

    // Frame B: gapped words, CiM already busy on arm.
    exp_pl = '{4'b0010, 4'b0001, 4'b0101, 4'b0110};
    i_cim_busy = 1'b1;
    write_word(4'd6);
    tick();
    tick();
    check("b_no_early_arm1", o_busy, 0);
    write_word(4'd9);
    tick();
    check("b_no_early_arm2", o_busy, 0);
    write_word(4'd12);
    check("b_busy", o_busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_held_off", o_cim_start, 0);
    end
    i_cim_busy = 1'b0;
    tick();
    check("b_start_after_drop", o_cim_start, 1);
    run_planes(4);

    // Frame C: reset lands in the middle of plane 2.
    exp_pl = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
    write_word(4'd1);
    write_word(4'd2);
    write_word(4'd4);
    run_planes(2);
    wait_start();
    check("c_bit_idx2", o_bit_idx, 2);
    check("c_plane2", o_cim_data, 4'b0100);
    i_cim_busy = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("c_rst_busy", o_busy, 0);
    check("c_rst_bit_idx", o_bit_idx, 0);
    check("c_rst_start", o_cim_start, 0);
    check("c_rst_done", o_done, 0);
    tick();
    rst = 1'b0;
    i_cim_busy = 1'b0;
    tick();

    // Frame D: fresh frame after reset.
    exp_pl = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
    s0 = n_start;
    write_word(4'd7);
    write_word(4'd0);
    write_word(4'd8);
    run_planes(4);
    check("d_start_count", n_start - s0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_inbuf.md
# fc_inbuf

Input buffer for a fully-connected layer. It sits directly downstream of the previous layer's func unit and directly upstream of this layer's CiM tiles. It collects `input_size` serially delivered activations, then drives them into the crossbar rows bit-serially, one bit-plane per CiM operation, LSB first. It back-pressures the upstream func unit through `o_busy` while a frame is being driven.

## Interface
Parameters:
- `input_size`, 512, activations per frame (crossbar rows used)
- `xbar_size`, 256, rows per crossbar tile
- `v_cim_tiles`, `(input_size+xbar_size-1)/xbar_size`, vertical tile count
- `datatype_size`, 8, bits per activation

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `i_valid`  in  1  upstream word valid
- `i_data`  in  `datatype_size`  upstream activation; unsigned
- `o_busy`  out  1  high = not accepting words; drives upstream `i_next_busy`
- `i_cim_busy`  in  1  CiM tiles busy
- `o_cim_start`  out  1  one-cycle pulse that launches one bit-plane operation
- `o_cim_data`  out  `[v_cim_tiles-1:0][xbar_size-1:0]`  current bit-plane, 1 bit per row
- `o_bit_idx`  out  `$clog2(datatype_size)`  index of the plane on `o_cim_data`
- `o_done`  out  1  one-cycle pulse after the last plane completes

## Operation
- Storage: `input_size` × `datatype_size` register array; write pointer `wr_addr` runs 0..`input_size-1`.
- States (`t_ibuf_state`): `s_ibuf_fill`, `s_ibuf_arm`, `s_ibuf_start`, `s_ibuf_wait`, `s_ibuf_done`.
- `s_ibuf_fill`:
  - `o_busy`=0.
  - When `i_valid`=1, write `buf[wr_addr]`=`i_data` and increment `wr_addr`.
  - On the write at `wr_addr`=`input_size-1`, go to `s_ibuf_arm` and clear `wr_addr` to 0.
- `s_ibuf_arm`: if `i_cim_busy`=0, go to `s_ibuf_start`; otherwise stay.
- `s_ibuf_start`: `o_cim_start`=1 for exactly this cycle, then go to `s_ibuf_wait`.
- `s_ibuf_wait`:
  - Entered the cycle after the start pulse. CiM must raise `i_cim_busy` in this first cycle; the first cycle therefore never exits.
  - From the 2nd cycle on, `i_cim_busy`=0 ends the plane:
    - `o_bit_idx` < `datatype_size-1`: increment `o_bit_idx`, go to `s_ibuf_arm`.
    - Otherwise: go to `s_ibuf_done`.
- `s_ibuf_done`: `o_done`=1 for one cycle, `o_bit_idx` returns to 0, go to `s_ibuf_fill`.
- `o_busy`=1 in every state except `s_ibuf_fill`.
  - `i_valid` while `o_busy`=1 is ignored; no write, no error.
- Plane mapping: `o_cim_data[t][r]` = `buf[t*xbar_size+r][o_bit_idx]`.
  - Rows with index ≥ `input_size` are driven 0 (padding).
- `o_cim_data` is a combinational function of the buffer and `o_bit_idx`. It is stable from `s_ibuf_arm` through `s_ibuf_wait` of each plane.

## Timing
- Reset values (async, immediate): state `s_ibuf_fill`, `wr_addr`=0, `o_bit_idx`=0, `o_busy`=0, `o_cim_start`=0, `o_done`=0.
- Buffer contents are not reset. `o_cim_data` is don't-care until the first full frame.
- `o_busy`, `o_cim_start` and `o_done` decode registered state only; no combinational path from `i_*`.
- Last word accepted at edge N:
  - `o_busy`=1 from cycle N+1.
  - Earliest `o_cim_start` at cycle N+2, when `i_cim_busy`=0 at N+1.
- Per plane, with minimum CiM busy time B≥1 cycles: start → `i_cim_busy` falls → next start ≥ 2 cycles later (arm + start).
- `o_done` is followed by `o_busy`=0 in the next cycle. A new frame's first word is accepted in that cycle.
- `rst` mid-frame or mid-plane: all progress is discarded and the block returns to the reset values. Upstream must restart the frame.

## Structure
- Shared package `rho_cim_pkg`:
  - `t_ibuf_state` enum, placed alongside the existing func-unit state enum.
  - Ceil-div helper function used for `v_cim_tiles`.
- Sub-module `fc_inbuf_plane_mux`: combinational buffer → bit-plane select, including zero padding. It is parameterised identically to the top.

## Test plan
Config for all scenarios: `input_size`=3, `xbar_size`=2, `datatype_size`=4, so `v_cim_tiles`=2.
- Write 3, 5, 10 with `i_valid` held high → `o_busy` rises after the 3rd word. Plane 0 = `[[1,1],[0,0]]`. Plane 3 = `[[0,0],[1,0]]`. Row 3 is always 0.
- Full frame with `i_cim_busy` held at 1 for 5 cycles after each start → exactly 4 `o_cim_start` pulses, `o_bit_idx` 0,1,2,3, one `o_done`, then `o_busy`=0.
- Drive `i_valid`=1 with value 15 while `o_busy`=1 → buffer unchanged and the next frame starts at `wr_addr`=0.
- `i_cim_busy`=1 already on entry to `s_ibuf_arm` → no start pulse until it drops. The pulse follows 1 cycle after the drop.
- Gaps in `i_valid` (pattern 1,0,0,1,0,1) → 3 words stored in order and no early arm.
- Assert `rst` during plane 2 → `o_busy`, `o_bit_idx` and `o_cim_start` are 0 immediately. Then a fresh 3-word frame completes normally.
